// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: one-hot column drive, 2-FF row synchroniser,
// press/release debounce and a single-cycle key_valid pulse per accepted key.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned DEBOUNCE_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned MAX_CYC = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld
  } state_e;

  state_e           state_q;
  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [3:0]       rows_s;
  logic [3:0]       pat_q;
  logic [3:0]       col_rot;
  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] deb_cnt_q;
  logic [CNT_W-1:0] rel_cnt_q;

  // Row lines are asynchronous to clk; only the second stage is ever looked at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= row_in;
      sync2_q <= sync1_q;
    end
  end

  assign rows_s  = sync2_q;
  assign col_rot = {col_out[2:0], col_out[3]};

  // Lowest active row wins when several rows are pressed together.
  function automatic logic [1:0] low_row(input logic [3:0] pat);
    logic [1:0] idx;
    if (pat[0])      idx = 2'd0;
    else if (pat[1]) idx = 2'd1;
    else if (pat[2]) idx = 2'd2;
    else             idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [1:0] col_idx(input logic [3:0] col);
    logic [1:0] idx;
    if (col[0])      idx = 2'd0;
    else if (col[1]) idx = 2'd1;
    else if (col[2]) idx = 2'd2;
    else             idx = 2'd3;
    return idx;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StScan;
      col_out   <= 4'b0001;
      pat_q     <= 4'b0000;
      div_cnt_q <= '0;
      deb_cnt_q <= '0;
      rel_cnt_q <= '0;
      key_code  <= 4'b0000;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state_q)
        StScan: begin
          if (div_cnt_q == SCAN_LAST) begin
            if (rows_s != 4'b0000) begin
              pat_q     <= rows_s;
              deb_cnt_q <= '0;
              state_q   <= StDebounce;
            end else begin
              col_out   <= col_rot;
              div_cnt_q <= '0;
            end
          end else begin
            div_cnt_q <= div_cnt_q + CNT_ONE;
          end
        end
        StDebounce: begin
          if (rows_s == pat_q) begin
            if (deb_cnt_q == DEB_LAST) begin
              state_q   <= StHeld;
              key_code  <= {low_row(pat_q), col_idx(col_out)};
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              rel_cnt_q <= '0;
            end else begin
              deb_cnt_q <= deb_cnt_q + CNT_ONE;
            end
          end else begin
            // Bounce or pattern change: abandon this key and move on.
            state_q   <= StScan;
            col_out   <= col_rot;
            div_cnt_q <= '0;
          end
        end
        StHeld: begin
          if (rows_s != 4'b0000) begin
            rel_cnt_q <= '0;
          end else if (rel_cnt_q == DEB_LAST) begin
            key_held  <= 1'b0;
            state_q   <= StScan;
            col_out   <= col_rot;
            div_cnt_q <= '0;
          end else begin
            rel_cnt_q <= rel_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q   <= StScan;
          col_out   <= 4'b0001;
          div_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a matrix model drives row_in from col_out,
// a reference model predicts per-cycle outputs and accepted keys, a monitor compares.
module tb_keypad_scan_ctrl;

  localparam int SD = 4;
  localparam int DC = 8;
  localparam int MScan = 0;
  localparam int MDeb  = 1;
  localparam int MHeld = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int vcount = 0;

  logic       press_on   = 1'b0;
  int         press_col  = 0;
  logic [3:0] press_rows = 4'b0000;
  logic [3:0] glitch     = 4'b0000;

  // Keypad matrix: a pressed key connects its row to its column drive.
  assign row_in = glitch |
                  ((press_on && (col_out == (4'b0001 << press_col))) ? press_rows : 4'b0000);

  keypad_scan_ctrl #(
    .SCAN_DIV    (SD),
    .DEBOUNCE_CYC(DC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] col;
    logic       held;
    logic       valid;
    logic [3:0] code;
  } stat_t;

  stat_t      stat_q[$];
  logic [3:0] key_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state: which column, how long in the slot, run lengths.
  int         m_mode, m_col, m_slot, m_run, m_quiet;
  logic [3:0] m_pat, m_h1, m_h2, m_code;
  logic       m_held;

  task automatic m_reset();
    m_mode  = MScan;
    m_col   = 0;
    m_slot  = 0;
    m_run   = 0;
    m_quiet = 0;
    m_pat   = 4'b0000;
    m_h1    = 4'b0000;
    m_h2    = 4'b0000;
    m_code  = 4'b0000;
    m_held  = 1'b0;
  endtask

  function automatic logic [1:0] lowest_row(input logic [3:0] p);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (p[i]) r = 2'(i);
    return r;
  endfunction

  // Model steps on the falling edge using the row_in the DUT captures next.
  always @(negedge clk) begin
    logic [3:0] rs;
    logic       fire;
    stat_t      s;
    if (rst) begin
      m_reset();
    end else begin
      rs   = m_h2;
      m_h2 = m_h1;
      m_h1 = row_in;
      fire = 1'b0;
      case (m_mode)
        MScan: begin
          if (m_slot == SD - 1) begin
            if (rs != 4'b0000) begin
              m_pat  = rs;
              m_run  = 0;
              m_mode = MDeb;
            end else begin
              m_col  = (m_col + 1) % 4;
              m_slot = 0;
            end
          end else begin
            m_slot++;
          end
        end
        MDeb: begin
          if (rs == m_pat) begin
            m_run++;
            if (m_run == DC) begin
              m_mode  = MHeld;
              m_held  = 1'b1;
              m_quiet = 0;
              m_code  = {lowest_row(m_pat), 2'(m_col)};
              fire    = 1'b1;
              key_q.push_back(m_code);
            end
          end else begin
            m_mode = MScan;
            m_col  = (m_col + 1) % 4;
            m_slot = 0;
          end
        end
        default: begin
          if (rs == 4'b0000) begin
            m_quiet++;
            if (m_quiet == DC) begin
              m_held = 1'b0;
              m_mode = MScan;
              m_col  = (m_col + 1) % 4;
              m_slot = 0;
            end
          end else begin
            m_quiet = 0;
          end
        end
      endcase
      s.col   = 4'b0001 << m_col;
      s.held  = m_held;
      s.valid = fire;
      s.code  = m_code;
      stat_q.push_back(s);
    end
  end

  // Monitor: compares each DUT cycle against the model and pops keys on key_valid.
  always @(posedge clk) begin
    stat_t s;
    #1;
    if (!rst && stat_q.size() > 0) begin
      s = stat_q.pop_front();
      chk("col_out", col_out, s.col);
      chk("key_held", key_held, s.held);
      chk("key_valid", key_valid, s.valid);
      chk("key_code_steady", key_code, s.code);
      if (key_valid) begin
        vcount++;
        if (key_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key: got key_valid code %0h expected no key (cycle %0d)",
                   key_code, cyc);
        end else begin
          chk("key_code", key_code, key_q.pop_front());
        end
      end else if (s.valid && key_q.size() > 0) begin
        void'(key_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int v0;
    step(3);
    chk("rst_col", col_out, 4'b0001);
    chk("rst_code", key_code, 4'b0000);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    rst = 1'b0;

    // Idle scanning
    v0 = vcount;
    step(40);
    chk("t1_no_valid", vcount, v0);

    // Key row 2 / column 1
    v0 = vcount;
    press_col = 1; press_rows = 4'b0100; press_on = 1'b1;
    step(60);
    chk("t2_pulses", vcount - v0, 1);
    chk("t2_code", key_code, 4'b1001);
    chk("t2_held", key_held, 1'b1);

    // Release timing
    press_on = 1'b0;
    step(9);
    chk("t3_held_before", key_held, 1'b1);
    step(1);
    chk("t3_held_after", key_held, 1'b0);
    chk("t3_col", col_out, 4'b0100);

    // Short glitch on column 0
    for (int i = 0; i < 20 && col_out != 4'b0001; i++) step(1);
    chk("t4_reach_col0", col_out, 4'b0001);
    v0 = vcount;
    glitch = 4'b0001;
    step(3);
    glitch = 4'b0000;
    step(20);
    chk("t4_no_valid", vcount, v0);

    // Two rows on column 3
    v0 = vcount;
    press_col = 3; press_rows = 4'b0110; press_on = 1'b1;
    step(40);
    chk("t5_pulses", vcount - v0, 1);
    chk("t5_code", key_code, 4'b0111);
    press_on = 1'b0;
    step(20);

    // Reset while held
    press_col = 2; press_rows = 4'b1000; press_on = 1'b1;
    step(40);
    chk("t6_held", key_held, 1'b1);
    rst = 1'b1;
    press_on = 1'b0;
    stat_q.delete();
    key_q.delete();
    #1;
    chk("t6_col", col_out, 4'b0001);
    chk("t6_code", key_code, 4'b0000);
    chk("t6_valid", key_valid, 1'b0);
    chk("t6_held_rst", key_held, 1'b0);
    step(3);
    rst = 1'b0;
    v0 = vcount;
    step(30);
    chk("t6_no_pulse", vcount, v0);

    // Random presses, pattern changes, glitches
    for (int it = 0; it < 40; it++) begin
      press_col  = int'($urandom_range(0, 3));
      press_rows = 4'($urandom_range(1, 15));
      press_on   = 1'b1;
      step(int'($urandom_range(1, 45)));
      if ($urandom_range(0, 3) == 0) begin
        press_rows = 4'($urandom_range(1, 15));
        step(int'($urandom_range(1, 20)));
      end
      press_on = 1'b0;
      if ($urandom_range(0, 4) == 0) begin
        glitch = 4'($urandom_range(1, 15));
        step(int'($urandom_range(1, 4)));
        glitch = 4'b0000;
      end
      step(int'($urandom_range(0, 25)));
    end
    step(30);
    chk("keys_drained", key_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
